// File: rtl/generador_pulsos_ad_pkg.sv
// Shared types and helpers for the up/down push-button strobe generator.
package generador_pulsos_ad_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFirst  = 2'd1,
    StHold   = 2'd2,
    StRepeat = 2'd3
  } canal_state_e;

  // Repeat periods below 2 would leave no low cycle between strobes.
  function automatic int unsigned clamp_repeat(input int unsigned cycles);
    return (cycles < 2) ? 2 : cycles;
  endfunction

endpackage

// File: rtl/generador_pulsos_ad_canal_boton.sv
// One button channel: 2-FF synchronizer, debouncer and press/hold/repeat FSM.
module canal_boton
  import generador_pulsos_ad_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CW            = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic force_idle,
  output logic stable,
  output logic req
);

  localparam int unsigned RepEff  = clamp_repeat(REPEAT_CYCLES);
  localparam int unsigned HoldEff = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

  localparam logic [CW-1:0] DebLim  = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] HoldLim = CW'(HoldEff);
  localparam logic [CW-1:0] RepLim  = CW'(RepEff - 1);
  localparam logic [CW-1:0] One     = CW'(1);

  logic [1:0]    sync_q;
  logic          s;
  logic          stable_q, stable_d;
  logic [CW-1:0] deb_q, deb_d;
  canal_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign s      = sync_q[1];
  assign stable = stable_q;

  always_comb begin
    stable_d = stable_q;
    deb_d    = '0;
    if (s != stable_q) begin
      if (deb_q == DebLim) begin
        stable_d = s;
      end else begin
        deb_d = deb_q + One;
      end
    end
  end

  // The FSM acts on the level being latched this edge, so the strobe register
  // at the top fires in the cycle right after stable rises.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    if (force_idle) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (stable_d) state_d = StFirst;
        end
        StFirst: begin
          req     = stable_d;
          cnt_d   = '0;
          state_d = stable_d ? StHold : StIdle;
        end
        StHold: begin
          if (!stable_d) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == HoldLim) begin
            state_d = StRepeat;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + One;
          end
        end
        StRepeat: begin
          if (!stable_d) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            req   = (cnt_q == '0);
            cnt_d = (cnt_q == RepLim) ? '0 : cnt_q + One;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      deb_q    <= '0;
      state_q  <= StIdle;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn};
      stable_q <= stable_d;
      deb_q    <= deb_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/generador_pulsos_ad.sv
// Two debounced button channels plus dual-press lockout and strobe arbitration.
module generador_pulsos_ad
  import generador_pulsos_ad_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CW            = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btnUP,
  input  logic btnDOWN,
  output logic enUP,
  output logic enDOWN,
  output logic bloqueo
);

  logic stable_up, stable_dn;
  logic req_up, req_dn;
  logic both_stable, suppress;
  logic up_q, up_d, dn_q, dn_d;
  logic lock_q, lock_d;
  logic pend_up_q, pend_up_d, pend_dn_q, pend_dn_d;
  logic want_up, want_dn;

  assign both_stable = stable_up && stable_dn;
  assign suppress    = lock_q || both_stable;

  canal_boton #(
    .DEB_CYCLES   (DEB_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CW           (CW)
  ) u_canal_up (
    .clk       (clk),
    .reset     (reset),
    .btn       (btnUP),
    .force_idle(suppress),
    .stable    (stable_up),
    .req       (req_up)
  );

  canal_boton #(
    .DEB_CYCLES   (DEB_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CW           (CW)
  ) u_canal_dn (
    .clk       (clk),
    .reset     (reset),
    .btn       (btnDOWN),
    .force_idle(suppress),
    .stable    (stable_dn),
    .req       (req_dn)
  );

  assign want_up = req_up || pend_up_q;
  assign want_dn = req_dn || pend_dn_q;

  always_comb begin
    lock_d    = lock_q ? (stable_up || stable_dn) : both_stable;
    up_d      = 1'b0;
    dn_d      = 1'b0;
    pend_up_d = 1'b0;
    pend_dn_d = 1'b0;
    // A request right behind the other channel's strobe waits one cycle.
    if (!suppress) begin
      if (want_up && want_dn) begin
        up_d = 1'b0;
      end else if (want_up) begin
        if (dn_q) pend_up_d = 1'b1;
        else      up_d      = 1'b1;
      end else if (want_dn) begin
        if (up_q) pend_dn_d = 1'b1;
        else      dn_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      lock_q    <= 1'b0;
      pend_up_q <= 1'b0;
      pend_dn_q <= 1'b0;
    end else begin
      up_q      <= up_d;
      dn_q      <= dn_d;
      lock_q    <= lock_d;
      pend_up_q <= pend_up_d;
      pend_dn_q <= pend_dn_d;
    end
  end

  assign enUP    = up_q;
  assign enDOWN  = dn_q;
  assign bloqueo = lock_q;

endmodule

// File: tb/tb_generador_pulsos_ad.sv
// Directed bench for generador_pulsos_ad with short debounce/hold/repeat counts.
module tb_generador_pulsos_ad;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 20;
  localparam int unsigned REP  = 6;
  localparam int unsigned CWB  = 8;

  logic clk = 1'b0;
  logic reset;
  logic btn_up, btn_dn;
  logic en_up, en_dn, bloqueo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  generador_pulsos_ad #(
    .DEB_CYCLES   (DEB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP),
    .CW           (CWB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btnUP  (btn_up),
    .btnDOWN(btn_dn),
    .enUP   (en_up),
    .enDOWN (en_dn),
    .bloqueo(bloqueo)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and compare {enUP,enDOWN,bloqueo}.
  task automatic cycle_check(input string tag, input int i, input logic eu, input logic ed,
                             input logic eb);
    @(posedge clk);
    #1;
    check_val($sformatf("%s[%0d]", tag, i), {29'd0, en_up, en_dn, bloqueo},
              {29'd0, eu, ed, eb});
  endtask

  task automatic idle(input int n);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_vals", {29'd0, en_up, en_dn, bloqueo}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 50; i++) cycle_check("idle", i, 1'b0, 1'b0, 1'b0);

    // Single press: one strobe, no repeat before release.
    for (int i = 0; i < 30; i++) begin
      btn_up = (i < 10);
      cycle_check("press_up", i, (i == 7), 1'b0, 1'b0);
    end
    idle(10);

    for (int i = 0; i < 20; i++) begin
      btn_up = (i < 3);
      cycle_check("glitch", i, 1'b0, 1'b0, 1'b0);
    end
    idle(10);

    // Held press: first strobe, then repeats after the hold time.
    for (int i = 0; i < 60; i++) begin
      btn_dn = (i < 45);
      cycle_check("hold_dn", i, 1'b0, (i inside {7, 28, 34, 40, 46}), 1'b0);
    end
    idle(10);

    for (int i = 0; i < 50; i++) begin
      btn_up = (i < 35);
      btn_dn = (i >= 5) && (i < 35);
      cycle_check("lock", i, (i == 7), 1'b0, (i >= 12) && (i <= 41));
    end
    idle(10);

    // Reset during the hold phase, button kept pressed throughout.
    btn_up = 1'b1;
    for (int i = 0; i < 8; i++) cycle_check("pre_rst", i, (i == 7), 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_val("rst_async", {29'd0, en_up, en_dn, bloqueo}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_held", {29'd0, en_up, en_dn, bloqueo}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      btn_up = (i < 20);
      cycle_check("post_rst", i, (i == 7), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
